hpdcache_mem_read_responder: RTL and testbench
==============================================

Name: hpdcache_mem_read_responder

Overview:
- Memory-side responder for the HPDcache miss/refill read interface; the far end of the channel the cache drives when it issues refill reads.
- Accepts one read request at a time and returns len+1 data beats with id, last and error flags.
- Data is a deterministic pattern derived from the beat address, so benches check refill contents without a backing store.
- Used as the memory model in cache-level testbenches and as a stub target in FPGA bring-up.

Parameters:
- PA_WIDTH, 49, physical address width (bits).
- MEM_DATA_WIDTH, 64, response data width (bits); power of 2, ≥ 8.
- MEM_ID_WIDTH, 7, transaction id width.
- LEN_WIDTH, 8, burst length field width; beats = len+1.
- LATENCY, 2, idle cycles between request acceptance and first beat; 0 allowed.
- ADDR_LIMIT, 2**32, first invalid byte address; requests at or above it respond with error.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous active-low reset.
- mem_req_read_valid_i  input  1  request valid.
- mem_req_read_ready_o  output  1  request ready.
- mem_req_read_addr_i  input  PA_WIDTH  request base byte address.
- mem_req_read_len_i  input  LEN_WIDTH  beats minus one.
- mem_req_read_size_i  input  3  log2 of bytes per beat.
- mem_req_read_id_i  input  MEM_ID_WIDTH  transaction id.
- mem_resp_read_valid_o  output  1  response beat valid.
- mem_resp_read_ready_i  input  1  response beat ready.
- mem_resp_read_data_o  output  MEM_DATA_WIDTH  beat data.
- mem_resp_read_id_o  output  MEM_ID_WIDTH  id of the owning request.
- mem_resp_read_last_o  output  1  final beat of the burst.
- mem_resp_read_error_o  output  1  request was erroneous.

Behaviour:
- Reset (rst_ni=0 at posedge):
  - State goes to IDLE; all registers clear.
  - Outputs: valid_o=0, ready_o=1, data_o=0, id_o=0, last_o=0, error_o=0.
  - Reset mid-burst abandons the burst; no further beats are issued.
- States IDLE, WAIT, SEND.
- IDLE:
  - ready_o=1.
  - On valid_i && ready_o, latch addr, len, size and id; load remaining=len.
  - Compute err = (size > log2(MEM_DATA_WIDTH/8)) || (addr >= ADDR_LIMIT).
  - Load wait counter=LATENCY.
  - Go to WAIT if LATENCY>0, else SEND.
- WAIT:
  - ready_o=0.
  - Decrement the counter each cycle; go to SEND when it reaches 1.
  - First valid_o therefore rises exactly LATENCY+1 cycles after the accepting edge.
- SEND:
  - ready_o=0; valid_o=1.
  - id_o = latched id.
  - last_o = (remaining==0).
  - error_o = err.
  - data_o = err ? 0 : beat address zero-extended/truncated to MEM_DATA_WIDTH.
  - Beat address starts at the latched addr; it advances by 2^size on each handshake, modulo 2^PA_WIDTH (wrap-around allowed, no error).
  - Handshake = valid_o && ready_i. On a handshake with remaining>0, decrement remaining.
  - On a handshake with last_o=1, go to IDLE; ready_o=1 the following cycle, giving one bubble between bursts.
  - When valid_o && !ready_i, data_o, id_o, last_o and error_o hold stable.
- Erroneous requests still produce exactly len+1 beats, all with error_o=1 and data 0.
- len=2^LEN_WIDTH-1 yields 2^LEN_WIDTH beats. remaining is LEN_WIDTH bits wide and counts down, so it never overflows.
- No pipelining of requests: request valid_i held during WAIT/SEND is not accepted until IDLE.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

Test Plan:
- Reset then single request (addr=0x1000, len=3, size=3, id=5, LATENCY=2, ready_i=1): accept at T, 4 beats at T+3..T+6 with data 0x1000, 0x1008, 0x1010, 0x1018, id_o=5, last_o only on 4th, error_o=0; ready_o=1 at T+7.
- Backpressure: same request, ready_i toggling 1,0,0,1,…: each beat's data/id/last held while ready_i=0; exactly 4 handshakes, data sequence unchanged.
- Errors: size=4 with MEM_DATA_WIDTH=64 → 4 beats, error_o=1, data 0. Separately, addr=ADDR_LIMIT → same result.
- Max length and wrap: len=255, size=3, addr=2^49-16 → 256 beats, last_o on beat 256, 3rd beat address wraps to 0x0 with error_o=0.
- LATENCY=0 build: accept at T → first valid_o at T+1. Back-to-back requests held valid → second accepted exactly one cycle after the first burst's last handshake.
- Reset asserted during 2nd beat of a len=7 burst: next cycle valid_o=0, ready_o=1. A new request (id=2) then completes normally with id_o=2, with no stale beats.

Source files
------------

// File: rtl/hpdcache_mem_read_responder_if.sv
// Read request/response channel between the HPDcache refill logic and memory.
interface hpdcache_mem_read_responder_if #(
  parameter int unsigned PA_WIDTH       = 49,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned MEM_ID_WIDTH   = 7,
  parameter int unsigned LEN_WIDTH      = 8
);
  logic                      mem_req_read_valid;
  logic                      mem_req_read_ready;
  logic [PA_WIDTH-1:0]       mem_req_read_addr;
  logic [LEN_WIDTH-1:0]      mem_req_read_len;
  logic [2:0]                mem_req_read_size;
  logic [MEM_ID_WIDTH-1:0]   mem_req_read_id;
  logic                      mem_resp_read_valid;
  logic                      mem_resp_read_ready;
  logic [MEM_DATA_WIDTH-1:0] mem_resp_read_data;
  logic [MEM_ID_WIDTH-1:0]   mem_resp_read_id;
  logic                      mem_resp_read_last;
  logic                      mem_resp_read_error;

  // Cache side: issues requests, consumes response beats.
  modport master (
    output mem_req_read_valid, mem_req_read_addr, mem_req_read_len, mem_req_read_size,
           mem_req_read_id, mem_resp_read_ready,
    input  mem_req_read_ready, mem_resp_read_valid, mem_resp_read_data, mem_resp_read_id,
           mem_resp_read_last, mem_resp_read_error
  );

  // Memory side: accepts requests, produces response beats.
  modport slave (
    input  mem_req_read_valid, mem_req_read_addr, mem_req_read_len, mem_req_read_size,
           mem_req_read_id, mem_resp_read_ready,
    output mem_req_read_ready, mem_resp_read_valid, mem_resp_read_data, mem_resp_read_id,
           mem_resp_read_last, mem_resp_read_error
  );
endinterface

// File: rtl/hpdcache_mem_read_responder.sv
// Memory-side read responder: one request at a time, len+1 beats whose data is the
// beat address, so refill contents can be checked without a backing store.
module hpdcache_mem_read_responder #(
  parameter int unsigned PA_WIDTH       = 49,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned MEM_ID_WIDTH   = 7,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned LATENCY        = 2,
  parameter logic [63:0] ADDR_LIMIT     = 64'h1_0000_0000
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  hpdcache_mem_read_responder_if.slave mem_io
);
  localparam int unsigned MaxSize = $clog2(MEM_DATA_WIDTH / 8);
  localparam int unsigned CntW    = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e                  state_q, state_d;
  logic [PA_WIDTH-1:0]     addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [2:0]              size_q, size_d;
  logic [MEM_ID_WIDTH-1:0] id_q, id_d;
  logic                    err_q, err_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    send;

  assign send = (state_q == StSend);

  // Outputs decode registered state only; nothing here depends on an input.
  assign mem_io.mem_req_read_ready  = (state_q == StIdle);
  assign mem_io.mem_resp_read_valid = send;
  assign mem_io.mem_resp_read_data  = (send && !err_q) ? MEM_DATA_WIDTH'(addr_q) : '0;
  assign mem_io.mem_resp_read_id    = send ? id_q : '0;
  assign mem_io.mem_resp_read_last  = send && (rem_q == '0);
  assign mem_io.mem_resp_read_error = send && err_q;

  // Next-state: request capture, latency countdown, beat sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    size_d  = size_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_io.mem_req_read_valid) begin
          addr_d = mem_io.mem_req_read_addr;
          rem_d  = mem_io.mem_req_read_len;
          size_d = mem_io.mem_req_read_size;
          id_d   = mem_io.mem_req_read_id;
          err_d  = (mem_io.mem_req_read_size > 3'(MaxSize)) ||
                   (64'(mem_io.mem_req_read_addr) >= ADDR_LIMIT);
          cnt_d  = CntW'(LATENCY);
          if (LATENCY == 0) state_d = StSend;
          else              state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) state_d = StSend;
      end
      StSend: begin
        if (mem_io.mem_resp_read_ready) begin
          if (rem_q == '0) begin
            state_d = StIdle;
          end else begin
            rem_d  = rem_q - LEN_WIDTH'(1);
            // Address wraps modulo 2^PA_WIDTH by construction.
            addr_d = addr_q + (PA_WIDTH'(1) << size_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Bench for hpdcache_mem_read_responder: instance A (LATENCY=2, limit 2^32) and
// instance B (LATENCY=0, limit 2^49), selected onto one set of stimulus signals.
module tb_hpdcache_mem_read_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  bit          sel;  // 0: instance A, 1: instance B
  logic        req_valid;
  logic [48:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [6:0]  req_id;
  logic        resp_ready;

  logic [48:0] nxt_addr;
  int          nxt_len, nxt_size, nxt_id;

  int total = 0;
  int bad   = 0;

  hpdcache_mem_read_responder_if #(.PA_WIDTH(49), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(7),
                                   .LEN_WIDTH(8)) if_a ();
  hpdcache_mem_read_responder_if #(.PA_WIDTH(49), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(7),
                                   .LEN_WIDTH(8)) if_b ();

  assign if_a.mem_req_read_valid  = req_valid && !sel;
  assign if_a.mem_req_read_addr   = req_addr;
  assign if_a.mem_req_read_len    = req_len;
  assign if_a.mem_req_read_size   = req_size;
  assign if_a.mem_req_read_id     = req_id;
  assign if_a.mem_resp_read_ready = resp_ready;
  assign if_b.mem_req_read_valid  = req_valid && sel;
  assign if_b.mem_req_read_addr   = req_addr;
  assign if_b.mem_req_read_len    = req_len;
  assign if_b.mem_req_read_size   = req_size;
  assign if_b.mem_req_read_id     = req_id;
  assign if_b.mem_resp_read_ready = resp_ready;

  logic        obs_ready, obs_valid, obs_last, obs_error;
  logic [63:0] obs_data;
  logic [6:0]  obs_id;
  assign obs_ready = sel ? if_b.mem_req_read_ready  : if_a.mem_req_read_ready;
  assign obs_valid = sel ? if_b.mem_resp_read_valid : if_a.mem_resp_read_valid;
  assign obs_data  = sel ? if_b.mem_resp_read_data  : if_a.mem_resp_read_data;
  assign obs_id    = sel ? if_b.mem_resp_read_id    : if_a.mem_resp_read_id;
  assign obs_last  = sel ? if_b.mem_resp_read_last  : if_a.mem_resp_read_last;
  assign obs_error = sel ? if_b.mem_resp_read_error : if_a.mem_resp_read_error;

  hpdcache_mem_read_responder #(
    .PA_WIDTH(49), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(7), .LEN_WIDTH(8),
    .LATENCY(2), .ADDR_LIMIT(64'h1_0000_0000)
  ) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .mem_io (if_a)
  );

  hpdcache_mem_read_responder #(
    .PA_WIDTH(49), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(7), .LEN_WIDTH(8),
    .LATENCY(0), .ADDR_LIMIT(64'h2_0000_0000_0000)
  ) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .mem_io (if_b)
  );

  // Issues one request and follows its burst to the end. Expected beat k sits at
  // base + k*2^size mod 2^49; error if size>3 or (instance A and base >= 2^32).
  // rmode: 0 always ready, 1 ready pattern 1,0,0 on valid cycles, 2 random.
  task automatic run_burst(input bit s, input logic [48:0] a, input int len, input int sz,
                           input int id, input int rmode, input int lat, input bit hold,
                           output int acc_wait);
    int          k, beat, vcnt, first_k;
    bit          err, rdy;
    logic [48:0] ba;
    logic [63:0] ed;
    sel       = s;
    req_addr  = a;
    req_len   = 8'(len);
    req_size  = 3'(sz);
    req_id    = 7'(id);
    req_valid = 1'b1;
    acc_wait  = 0;
    while (!obs_ready && acc_wait < 600) begin
      @(posedge clk); #1;
      acc_wait++;
    end
    total++;
    if (!obs_ready) begin
      bad++;
      $display("FAIL accept_timeout: ready_o got %0b want 1", obs_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (hold) begin
      req_addr = nxt_addr;
      req_len  = 8'(nxt_len);
      req_size = 3'(nxt_size);
      req_id   = 7'(nxt_id);
    end else begin
      req_valid = 1'b0;
    end
    err     = (sz > 3) || (!s && (a >= 49'h1_0000_0000));
    beat    = 0;
    k       = 1;
    vcnt    = 0;
    first_k = -1;
    while (beat <= len && k < 3000) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (vcnt % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      resp_ready = rdy;
      total++;
      if (obs_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready k=%0d: got %0b want 0", k, obs_ready);
      end
      if (obs_valid === 1'b1) begin
        if (first_k < 0) begin
          first_k = k;
          total++;
          if (k != lat + 1) begin
            bad++;
            $display("FAIL first_beat_latency: got %0d want %0d", k, lat + 1);
          end
        end
        ba = a + (49'(beat) << sz);
        ed = err ? 64'd0 : {15'd0, ba};
        total += 4;
        if (obs_data !== ed) begin
          bad++;
          $display("FAIL beat_data #%0d: got %h want %h", beat, obs_data, ed);
        end
        if (obs_id !== 7'(id)) begin
          bad++;
          $display("FAIL beat_id #%0d: got %0d want %0d", beat, obs_id, id);
        end
        if (obs_last !== (beat == len)) begin
          bad++;
          $display("FAIL beat_last #%0d: got %0b want %0b", beat, obs_last, beat == len);
        end
        if (obs_error !== err) begin
          bad++;
          $display("FAIL beat_error #%0d: got %0b want %0b", beat, obs_error, err);
        end
        if (rdy) beat++;
        vcnt++;
      end else if (first_k < 0 && k > lat + 1) begin
        total++;
        bad++;
        $display("FAIL first_beat_missing k=%0d: got valid 0 want 1", k);
        first_k = k;
      end
      @(posedge clk); #1;
      k++;
    end
    resp_ready = 1'b1;
    total++;
    if (beat <= len) begin
      bad++;
      $display("FAIL burst_timeout: got %0d beats want %0d", beat, len + 1);
    end else if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_burst: got valid %0b ready %0b want 0 1", obs_valid, obs_ready);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; sel = 1'b0;
    req_addr = '0; req_len = '0; req_size = '0; req_id = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    total += 3;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_handshake: got valid %0b ready %0b want 0 1", obs_valid, obs_ready);
    end
    if (obs_data !== 64'd0 || obs_id !== 7'd0) begin
      bad++;
      $display("FAIL reset_data_id: got %h %0d want 0 0", obs_data, obs_id);
    end
    if (obs_last !== 1'b0 || obs_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_last_err: got %0b %0b want 0 0", obs_last, obs_error);
    end
  endtask

  task automatic test_single();
    int w;
    run_burst(1'b0, 49'h1000, 3, 3, 5, 0, 2, 1'b0, w);
  endtask

  task automatic test_backpressure();
    int w;
    run_burst(1'b0, 49'h1000, 3, 3, 5, 1, 2, 1'b0, w);
    run_burst(1'b1, 49'h1000, 3, 3, 5, 1, 0, 1'b0, w);
  endtask

  task automatic test_errors();
    int w;
    run_burst(1'b0, 49'h1000, 3, 4, 1, 0, 2, 1'b0, w);
    run_burst(1'b0, 49'h1_0000_0000, 3, 3, 1, 0, 2, 1'b0, w);
    run_burst(1'b0, 49'h1_2345_6780, 2, 2, 3, 1, 2, 1'b0, w);
  endtask

  task automatic test_max_len_wrap();
    int w;
    run_burst(1'b1, 49'h1_FFFF_FFFF_FFF0, 255, 3, 11, 0, 0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    nxt_addr = 49'h40; nxt_len = 1; nxt_size = 2; nxt_id = 9;
    run_burst(1'b1, 49'h100, 2, 3, 8, 0, 0, 1'b1, w);
    run_burst(1'b1, nxt_addr, nxt_len, nxt_size, nxt_id, 0, 0, 1'b0, w);
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL back_to_back_accept: got wait %0d want 0", w);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc, w;
    bit seen;
    sel = 1'b0; resp_ready = 1'b1;
    req_addr = 49'h2000; req_len = 8'd7; req_size = 3'd3; req_id = 7'd6; req_valid = 1'b1;
    cyc = 0;
    while (!obs_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      if (obs_valid) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (obs_valid !== 1'b1 || obs_data !== 64'h2008) begin
      bad++;
      $display("FAIL mid_burst_beat2: got valid %0b data %h want 1 2008", obs_valid, obs_data);
    end
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    total++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_burst_reset: got valid %0b ready %0b want 0 1", obs_valid, obs_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_beat cycle %0d: got valid %0b want 0", i, obs_valid);
      end
    end
    run_burst(1'b0, 49'h3000, 2, 3, 2, 0, 2, 1'b0, w);
  endtask

  task automatic test_random();
    int          w, s, sz, len, id;
    logic [63:0] r;
    logic [48:0] a;
    for (int i = 0; i < 24; i++) begin
      s   = $urandom_range(0, 1);
      sz  = $urandom_range(0, 4);
      len = $urandom_range(0, 15);
      id  = $urandom_range(0, 127);
      r   = {$urandom(), $urandom()};
      a   = r[48:0];
      if ($urandom_range(0, 1) == 1) a[48:32] = '0;
      run_burst(s[0], a, len, sz, id, 2, (s == 1) ? 0 : 2, 1'b0, w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_errors();
    test_max_len_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
